// File: rtl/modexp_engine.sv
// Right-to-left square-and-multiply modular exponentiation engine.
// Two bit-serial interleaved modular multipliers share the multiplier b.
module modexp_engine #(
    parameter int mbit = 63
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [mbit:0]   base,
    input  logic [mbit:0]   exponent,
    input  logic [mbit:0]   modulus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [mbit:0]   result
);

    localparam int W  = mbit + 1;
    localparam int CW = $clog2(W);
    localparam logic [mbit:0] ONE = {{mbit{1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_NEXT,
        S_DONE
    } state_t;

    state_t         state_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic [mbit:0]  result_q;
    logic [mbit:0]  r_q, b_q, e_q, n_q;
    logic [mbit:0]  pr_q, pb_q;
    logic [CW-1:0]  step_q;

    logic [mbit:0]  pr_d, pb_d, e_d, r_d;
    logic           mbit_d;
    logic           bad_op;

    // One interleaved step: acc = 2*acc + (bit ? a : 0) mod n, kept < n.
    function automatic logic [mbit:0] mm_step(
        input logic [mbit:0] acc,
        input logic [mbit:0] a,
        input logic [mbit:0] n,
        input logic          bit_i
    );
        logic [mbit+1:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        if (bit_i) begin
            t = t + {1'b0, a};
            if (t >= {1'b0, n}) t = t - {1'b0, n};
        end
        return t[mbit:0];
    endfunction

    always_comb begin
        mbit_d = b_q[step_q];
        pr_d   = mm_step(pr_q, r_q, n_q, mbit_d);
        pb_d   = mm_step(pb_q, b_q, n_q, mbit_d);
        e_d    = e_q >> 1;
        r_d    = e_q[0] ? pr_q : r_q;
        bad_op = (modulus[mbit:1] == '0) || (base >= modulus);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            r_q      <= '0;
            b_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            pr_q     <= '0;
            pb_q     <= '0;
            step_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (bad_op) begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (exponent == '0) begin
                            err_q    <= 1'b0;
                            result_q <= ONE;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            r_q     <= ONE;
                            b_q     <= base;
                            e_q     <= exponent;
                            n_q     <= modulus;
                            pr_q    <= '0;
                            pb_q    <= '0;
                            step_q  <= LAST;
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    pr_q <= pr_d;
                    pb_q <= pb_d;
                    if (step_q == '0) begin
                        state_q <= S_NEXT;
                    end else begin
                        step_q <= step_q - 1'b1;
                    end
                end
                S_NEXT: begin
                    r_q <= r_d;
                    b_q <= pb_q;
                    e_q <= e_d;
                    if (e_d == '0) begin
                        err_q    <= 1'b0;
                        result_q <= r_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        pr_q    <= '0;
                        pb_q    <= '0;
                        step_q  <= LAST;
                        state_q <= S_MUL;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_modexp_engine.sv
// Scoreboard bench for modexp_engine: a 64-bit and a 16-bit instance,
// expected result, err and done cycle queued at start, checked at done.
module tb_modexp_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_l = 1'b0;
    logic        start_s = 1'b0;
    logic [63:0] base_t = '0;
    logic [63:0] expo_t = '0;
    logic [63:0] mod_t = '0;
    logic        busy_l, done_l, err_l;
    logic [63:0] res_l;
    logic        busy_s, done_s, err_s;
    logic [15:0] res_s;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] r;
        logic        e;
        int          cyc;
    } sb_t;

    sb_t sb_q[$];

    always #5 clk = ~clk;

    modexp_engine #(.mbit(63)) u_dut (
        .clk(clk), .rst(rst), .start(start_l),
        .base(base_t), .exponent(expo_t), .modulus(mod_t),
        .busy(busy_l), .done(done_l), .err(err_l), .result(res_l)
    );

    modexp_engine #(.mbit(15)) u_small (
        .clk(clk), .rst(rst), .start(start_s),
        .base(base_t[15:0]), .exponent(expo_t[15:0]),
        .modulus(mod_t[15:0]),
        .busy(busy_s), .done(done_s), .err(err_s), .result(res_s)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int bitlen(input logic [63:0] e);
        int k = 0;
        for (int i = 0; i < 64; i++) if (e[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [63:0] ref_pow(input logic [63:0] b,
                                           input logic [63:0] e,
                                           input logic [63:0] n);
        logic [127:0] r, x, nn;
        nn = {64'd0, n};
        r  = 128'd1 % nn;
        x  = {64'd0, b} % nn;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[63:0];
    endfunction

    function automatic logic g_busy(input bit sm);
        return sm ? busy_s : busy_l;
    endfunction
    function automatic logic g_done(input bit sm);
        return sm ? done_s : done_l;
    endfunction
    function automatic logic g_err(input bit sm);
        return sm ? err_s : err_l;
    endfunction
    function automatic logic [63:0] g_res(input bit sm);
        return sm ? {48'd0, res_s} : res_l;
    endfunction

    // Called at a negedge; drives start for the current cycle (cycle 0).
    task automatic run_job(input bit sm, input logic [63:0] b,
                           input logic [63:0] e, input logic [63:0] n,
                           input logic [63:0] xr, input logic xe,
                           input bit noise);
        int  w;
        int  xcyc;
        bit  seen;
        sb_t x;
        w    = sm ? 16 : 64;
        xcyc = (xe || e == 0) ? 1 : 1 + bitlen(e) * (w + 1);
        sb_q.push_back('{xr, xe, xcyc});
        base_t = b;
        expo_t = e;
        mod_t  = n;
        if (sm) start_s = 1'b1;
        else start_l = 1'b1;
        seen = 0;
        for (int c = 1; c <= xcyc + 3 && !seen; c++) begin
            @(negedge clk);
            if (noise) begin
                base_t = {$urandom, $urandom};
                expo_t = {$urandom, $urandom};
                mod_t  = {$urandom, $urandom};
            end else begin
                start_l = 1'b0;
                start_s = 1'b0;
            end
            chk("busy", 64'(g_busy(sm)), 64'd1);
            if (g_done(sm)) begin
                x = sb_q.pop_front();
                chk("result", g_res(sm), x.r);
                chk("err", 64'(g_err(sm)), 64'(x.e));
                chk("done_cycle", 64'(c), 64'(x.cyc));
                seen = 1;
            end
        end
        if (!seen) begin
            chk("timeout", 64'd0, 64'd1);
            void'(sb_q.pop_front());
        end
        @(negedge clk);
        start_l = 1'b0;
        start_s = 1'b0;
        chk("idle_busy", 64'(g_busy(sm)), 64'd0);
        chk("done_pulse", 64'(g_done(sm)), 64'd0);
        chk("hold_result", g_res(sm), xr);
        chk("hold_err", 64'(g_err(sm)), 64'(xe));
    endtask

    initial begin
        logic [63:0] rb, re, rn;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy_l), 64'd0);
        chk("rst_done", 64'(done_l), 64'd0);
        chk("rst_err", 64'(err_l), 64'd0);
        chk("rst_result", res_l, 64'd0);
        chk("rst_busy_s", 64'(busy_s), 64'd0);
        chk("rst_result_s", 64'(res_s), 64'd0);

        run_job(1, 64'd4, 64'd13, 64'd497, 64'd445, 1'b0, 0);
        run_job(0, 64'd65, 64'd17, 64'd3233, 64'd2790, 1'b0, 0);
        run_job(0, 64'd2790, 64'd2753, 64'd3233, 64'd65, 1'b0, 0);
        run_job(0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        run_job(0, 64'd5, 64'd0, 64'd7, 64'd1, 1'b0, 0);
        run_job(0, 64'd500, 64'd3, 64'd497, 64'd0, 1'b1, 0);
        run_job(0, 64'd0, 64'd3, 64'd1, 64'd0, 1'b1, 0);
        run_job(0, 64'd0, 64'd3, 64'd0, 64'd0, 1'b1, 0);
        run_job(1, 64'd9, 64'd5, 64'd1, 64'd0, 1'b1, 0);

        run_job(0, 64'd65, 64'd17, 64'd3233, 64'd2790, 1'b0, 1);
        run_job(1, 64'd4, 64'd13, 64'd497, 64'd445, 1'b0, 1);

        // Abort a running job, then restart right after reset drops.
        base_t  = 64'd7;
        expo_t  = 64'd12345;
        mod_t   = 64'd100003;
        start_l = 1'b1;
        repeat (20) begin
            @(negedge clk);
            start_l = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy_l), 64'd0);
        chk("abort_done", 64'(done_l), 64'd0);
        chk("abort_result", res_l, 64'd0);
        chk("abort_err", 64'(err_l), 64'd0);
        run_job(0, 64'd65, 64'd17, 64'd3233, 64'd2790, 1'b0, 0);

        for (int i = 0; i < 3; i++) begin
            rn = {$urandom, $urandom};
            if (rn < 2) rn = 64'd3;
            rb = {$urandom, $urandom} % rn;
            re = 64'($urandom_range(1, 65535));
            run_job(0, rb, re, rn, ref_pow(rb, re, rn), 1'b0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            rn = 64'($urandom_range(2, 65535));
            rb = 64'($urandom_range(0, 65535)) % rn;
            re = 64'($urandom_range(1, 65535));
            run_job(1, rb, re, rn, ref_pow(rb, re, rn), 1'b0, 0);
        end
        rb = 64'h1234_5678_9ABC_DEF0;
        rn = 64'hFFFF_FFFF_FFFF_FFC5;
        re = 64'hFFFF_FFFF_FFFF_FFFF;
        run_job(0, rb, re, rn, ref_pow(rb, re, rn), 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modexp_engine.md
# modexp_engine

Sequential modular-exponentiation engine computing result = base^exponent mod modulus. It is the consumer side of key generation: the RSA encrypt/decrypt datapath that applies a generated public exponent e or private exponent d to a message or ciphertext. It uses right-to-left square-and-multiply built on bit-serial interleaved modular multiplication, so no wide multiplier is needed. A one-cycle start/done handshake drives it from the RSA top level.

## Interface

Parameters:
- mbit, default 63: MSB index of all operands; W = mbit+1 bits per operand.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- base  in  W  message or ciphertext; sampled with start.
- exponent  in  W  e or d; sampled with start.
- modulus  in  W  n; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse, result and err valid.
- err  out  1  operand error flag; valid with done, held until the next accepted start.
- result  out  W  base^exponent mod modulus; held until the next accepted start.

## Operation

- States: IDLE, MUL, NEXT, DONE.
- IDLE with start=1: capture operands and check them.
  - Error: modulus < 2 or base ≥ modulus. Go to DONE with err=1 and result=0.
  - Else if exponent == 0: go to DONE with result=1, err=0.
  - Else: r=1, b=base, e=exponent, err=0, step counter=W-1; go to MUL.
- MUL runs W cycles, step i = W-1 down to 0. Two interleaved multipliers run in parallel, both with multiplier b:
  - pr = r·b mod n.
  - pb = b·b mod n.
  - Per step, for each accumulator acc with multiplicand a:
    - t = 2·acc; if t ≥ n, t -= n.
    - If b[i]: t += a; if t ≥ n, t -= n.
  - Intermediates are W+1 bits wide. All values are kept < n.
  - b and r stay stable during MUL.
- NEXT (1 cycle):
  - If e[0]: r ← pr.
  - b ← pb; e ← e>>1.
  - If the shifted e == 0, go to DONE; else reload the step counter and go to MUL.
- DONE (1 cycle): done=1, result=r (or the error/zero-exponent value); then go to IDLE.
- start is ignored while busy=1 (including the DONE cycle). No queuing.
- The operand input ports are don't-care except in the start cycle.
- Reset values: state=IDLE, busy=0, done=0, err=0, result=0. Internal r, b, e, pr, pb are cleared to 0.
- rst=1 mid-operation aborts the computation with no done pulse. The first start is accepted in the first cycle after rst deasserts.
- modulus may be any odd or even value ≥ 2, up to 2^W-1.

## Timing

- Cycle 0 is the cycle where start=1 is sampled in IDLE.
- k = bit length of exponent (index of highest set bit + 1; k=0 for exponent 0).
- done is high in cycle 1 + k·(W+1). busy is high in cycles 1 through 1 + k·(W+1).
- Error case and exponent==0: done in cycle 1.
- Back-to-back throughput: the next start can be accepted in the cycle after DONE, i.e. cycle 2 + k·(W+1).
- result and err change only on the DONE transition or on reset.

## Test plan

- mbit=15, base=4, exponent=13, modulus=497 -> done in cycle 69, result=445, err=0, busy high cycles 1..69.
- mbit=63, base=65, exponent=17, modulus=3233 -> result=2790, done in cycle 326. Then base=2790, exponent=2753, modulus=3233 -> result=65, done in cycle 781.
- mbit=63, base=2^64-2, exponent=2, modulus=2^64-1 -> result=1 (checks W+1-bit intermediates). Also exponent=0 with base=5, modulus=7 -> result=1, done in cycle 1.
- Error cases, each giving done in cycle 1 with err=1 and result=0:
  - base=500, modulus=497.
  - modulus=1.
  - modulus=0.
- Pulse start=1 with different operands at every cycle during an active computation -> ignored, and the original result is delivered at the original cycle.
- Assert rst for 1 cycle at cycle 20 of a running job -> busy=0, done=0, result=0, err=0 next cycle, and no done pulse appears afterwards. A new start in the next cycle gives correct results on the standard timeline.
